// File: rtl/accum_rr_sched.sv
// Round-robin arbiter sharing one wrap-around accumulator among NUM_REQ requesters.
// Each transaction takes grant -> latch -> add, and is acknowledged with a one-cycle ack.
//
// state | meaning
// IDLE  | no transaction; arbitrate among req & ~ack
// LATCH | winner granted; capture its operand, or abort if req withdrawn
// ADD   | accumulate the latched operand, issue ack, advance priority pointer
module accum_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] value_flat,
  input  logic                      clear,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [DATA_W-1:0]         acc_out,
  output logic                      ovf,
  output logic [7:0]                led
);

  localparam int              IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW:0]     N_W       = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0]   LAST_INIT = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LATCH, ADD} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       last;
  logic [IW-1:0]       winner;
  logic                found;
  logic [NUM_REQ-1:0]  eff_req;
  logic [IW:0]         pos;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   vals [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      vals[i] = value_flat[i*DATA_W +: DATA_W];
    end
  end

  // Search last+1, last+2, ... modulo NUM_REQ; a requester is masked while its ack is visible.
  always_comb begin
    eff_req = req & ~ack;
    winner  = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = {1'b0, last} + (IW+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (!found && eff_req[pos[IW-1:0]]) begin
        found  = 1'b1;
        winner = pos[IW-1:0];
      end
    end
  end

  assign sum = {1'b0, acc_out} + {1'b0, operand};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      acc_out <= '0;
      ovf     <= 1'b0;
      last    <= LAST_INIT;
      idx     <= '0;
      operand <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= NUM_REQ'(1) << winner;
            idx   <= winner;
            state <= LATCH;
          end
        end
        LATCH: begin
          if (req[idx]) begin
            operand <= vals[idx];
            state   <= ADD;
          end else begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
        ADD: begin
          acc_out <= sum[DATA_W-1:0];
          ovf     <= ovf | sum[DATA_W];
          ack     <= NUM_REQ'(1) << idx;
          gnt     <= '0;
          last    <= idx;
          state   <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
      // clear wins over a same-cycle add; the ack above is still issued
      if (clear) begin
        acc_out <= '0;
        ovf     <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign led  = acc_out[23:16];

endmodule

// File: tb/tb_accum_rr_sched.sv
// Self-checking bench for accum_rr_sched: directed scenarios plus a randomized run
// against a transaction-level round-robin / accumulate reference model.
module tb_accum_rr_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] req;
  logic [N*W-1:0] value_flat;
  logic         clear;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic         busy;
  logic [W-1:0] acc_out;
  logic         ovf;
  logic [7:0]   led;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  accum_rr_sched #(.NUM_REQ(N), .DATA_W(W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .value_flat(value_flat), .clear(clear),
    .gnt(gnt), .ack(ack), .busy(busy), .acc_out(acc_out), .ovf(ovf), .led(led)
  );

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; req = '0; clear = 1'b0; value_flat = '0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic set_val(input int i, input logic [W-1:0] v);
    value_flat[i*W +: W] = v;
  endtask

  task automatic run_txn(input int i, input logic [W-1:0] v, output bit got);
    got = 1'b0;
    set_val(i, v);
    req[i] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack[i]) begin got = 1'b1; break; end
    end
    req[i] = 1'b0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] e, input int last);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (gnt !== 4'b0)     begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    total++; if (ack !== 4'b0)     begin bad++; $display("FAIL rst_ack got=%b exp=0000", ack); end
    total++; if (acc_out !== 32'd0) begin bad++; $display("FAIL rst_acc got=%h exp=0", acc_out); end
    total++; if (ovf !== 1'b0)     begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    set_val(0, 32'd5);
    req = 4'b0001;
    for (int c = 1; c <= 2; c++) begin
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt c%0d got=%b exp=0001", c, gnt); end
      total++; if (busy !== 1'b1)   begin bad++; $display("FAIL single_busy c%0d got=%b exp=1", c, busy); end
      total++; if (ack !== 4'b0)    begin bad++; $display("FAIL single_noack c%0d got=%b exp=0000", c, ack); end
    end
    tick();
    total++; if (ack !== 4'b0001)   begin bad++; $display("FAIL single_ack got=%b exp=0001", ack); end
    total++; if (gnt !== 4'b0)      begin bad++; $display("FAIL single_gnt_drop got=%b exp=0000", gnt); end
    total++; if (acc_out !== 32'd5) begin bad++; $display("FAIL single_acc got=%h exp=5", acc_out); end
    total++; if (led !== 8'h00)     begin bad++; $display("FAIL single_led got=%h exp=00", led); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
    req = 4'b0;
    tick();
    total++; if (ack !== 4'b0)      begin bad++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
  endtask

  task automatic test_all_four();
    int n;
    do_reset();
    for (int i = 0; i < N; i++) set_val(i, 32'(i + 1));
    req = 4'b1111;
    n = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      total++;
      if (gnt !== 4'b0 && ack !== 4'b0) begin bad++; $display("FAIL all4_gnt_ack_overlap c%0d gnt=%b ack=%b", c, gnt, ack); end
      if (gnt !== 4'b0 && n < N) begin
        total++; if (gnt !== (4'(1) << n)) begin bad++; $display("FAIL all4_gnt c%0d got=%b exp=%b", c, gnt, 4'(1) << n); end
      end
      if (ack !== 4'b0 && n < N) begin
        total++; if (ack !== (4'(1) << n)) begin bad++; $display("FAIL all4_ack c%0d got=%b exp=%b", c, ack, 4'(1) << n); end
        total++; if (c !== 3*(n+1)) begin bad++; $display("FAIL all4_ack_cycle got=%0d exp=%0d", c, 3*(n+1)); end
        req = req & ~ack;
        n++;
      end
    end
    total++; if (n !== 4)            begin bad++; $display("FAIL all4_count got=%0d exp=4", n); end
    total++; if (acc_out !== 32'd10) begin bad++; $display("FAIL all4_acc got=%0d exp=10", acc_out); end
    total++; if (ovf !== 1'b0)       begin bad++; $display("FAIL all4_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_wrap();
    bit got;
    do_reset();
    run_txn(0, 32'hFFFF_FFFE, got);
    total++; if (!got) begin bad++; $display("FAIL wrap_ack0 got=timeout exp=ack"); end
    total++; if (acc_out !== 32'hFFFF_FFFE || ovf !== 1'b0) begin bad++; $display("FAIL wrap_pre got=%h/%b exp=fffffffe/0", acc_out, ovf); end
    run_txn(1, 32'd3, got);
    total++; if (!got) begin bad++; $display("FAIL wrap_ack1 got=timeout exp=ack"); end
    total++; if (acc_out !== 32'h0000_0001) begin bad++; $display("FAIL wrap_acc got=%h exp=00000001", acc_out); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf got=%b exp=1", ovf); end
    run_txn(2, 32'h0012_0000, got);
    total++; if (!got) begin bad++; $display("FAIL wrap_ack2 got=timeout exp=ack"); end
    total++; if (led !== 8'h12) begin bad++; $display("FAIL wrap_led got=%h exp=12", led); end
    total++; if (acc_out !== 32'h0012_0001) begin bad++; $display("FAIL wrap_acc2 got=%h exp=00120001", acc_out); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL wrap_ovf_sticky got=%b exp=1", ovf); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (acc_out !== 32'd0 || ovf !== 1'b0) begin bad++; $display("FAIL wrap_clear got=%h/%b exp=0/0", acc_out, ovf); end
  endtask

  task automatic test_withdraw();
    do_reset();
    set_val(0, 32'd7); set_val(1, 32'd9);
    req = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wd_gnt0 got=%b exp=0001", gnt); end
    req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0 || busy !== 1'b0 || ack !== 4'b0) begin bad++; $display("FAIL wd_abort gnt=%b busy=%b ack=%b exp=0000/0/0000", gnt, busy, ack); end
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wd_gnt1 got=%b exp=0010", gnt); end
    tick();
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL wd_early_ack got=%b exp=0000", ack); end
    tick();
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL wd_ack1 got=%b exp=0010", ack); end
    total++; if (acc_out !== 32'd9) begin bad++; $display("FAIL wd_acc got=%0d exp=9", acc_out); end
    req = 4'b0;
    tick();
    req = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wd_after_gnt got=%b exp=0001", gnt); end
    // an abort must not move the pointer: 0 still beats 1 right after it
    do_reset();
    set_val(0, 32'd7); set_val(1, 32'd9);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wd_ptr_kept got=%b exp=0001", gnt); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] reraise;
    logic [N-1:0] prev_g;
    int exp_next, ngr;
    do_reset();
    set_val(0, 32'd1); set_val(2, 32'd2);
    req = 4'b0101;
    reraise = '0; prev_g = '0; exp_next = 0; ngr = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      req = req | reraise;
      reraise = '0;
      if (ack !== 4'b0) begin reraise = ack; req = req & ~ack; end
      if (gnt !== 4'b0 && prev_g === 4'b0) begin
        total++; if (gnt !== (4'(1) << exp_next)) begin bad++; $display("FAIL fair_gnt #%0d got=%b exp=%b", ngr, gnt, 4'(1) << exp_next); end
        exp_next = (exp_next == 0) ? 2 : 0;
        ngr++;
      end
      prev_g = gnt;
    end
    total++; if (ngr !== 8) begin bad++; $display("FAIL fair_count got=%0d exp=8", ngr); end
  endtask

  task automatic test_reset_mid();
    bit got;
    do_reset();
    run_txn(0, 32'h10, got);
    total++; if (!got || acc_out !== 32'h10) begin bad++; $display("FAIL rmid_pre got=%h exp=10", acc_out); end
    set_val(1, 32'd100);
    req = 4'b0010;
    tick(); tick();
    RST = 1'b1; req = 4'b0;
    tick();
    RST = 1'b0;
    total++; if (gnt !== 4'b0 || ack !== 4'b0) begin bad++; $display("FAIL rmid_hs gnt=%b ack=%b exp=0000/0000", gnt, ack); end
    total++; if (acc_out !== 32'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_state acc=%h busy=%b exp=0/0", acc_out, busy); end
    tick();
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL rmid_dropped got=%b exp=0000", ack); end
    set_val(1, 32'd50);
    req = 4'b0010;
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++; if (ack !== 4'b0010) begin bad++; $display("FAIL clr_add_ack got=%b exp=0010", ack); end
    total++; if (acc_out !== 32'd0) begin bad++; $display("FAIL clr_add_acc got=%0d exp=0", acc_out); end
    req = 4'b0;
    tick();
  endtask

  task automatic test_random();
    int phase, idx, last, w;
    longint macc;
    bit movf, prev_clear;
    logic [N-1:0] prev_req, m_ack_prev, just_acked, exp_gnt, exp_ack;
    logic exp_busy;
    logic [W-1:0] vals [N];
    logic [W-1:0] macc_w;
    do_reset();
    phase = 0; idx = 0; last = N - 1; macc = 0; movf = 1'b0;
    m_ack_prev = '0; just_acked = '0;
    for (int i = 0; i < N; i++) vals[i] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !just_acked[i] && $urandom_range(0, 2) == 0) begin
          vals[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h00FF_FFFF));
          set_val(i, vals[i]);
          req[i] = 1'b1;
        end
      end
      clear = ($urandom_range(0, 15) == 0);
      prev_req = req; prev_clear = clear;
      tick();
      exp_gnt = '0; exp_ack = '0; exp_busy = 1'b0;
      case (phase)
        0: begin
          w = rr_pick(prev_req & ~m_ack_prev, last);
          if (w >= 0) begin idx = w; exp_gnt = 4'(1) << idx; exp_busy = 1'b1; phase = 1; end
        end
        1: begin exp_gnt = 4'(1) << idx; exp_busy = 1'b1; phase = 2; end
        default: begin
          exp_ack = 4'(1) << idx; last = idx; phase = 0;
          macc = macc + longint'(vals[idx]);
          if (macc > 64'hFFFF_FFFF) movf = 1'b1;
          macc = macc & 64'hFFFF_FFFF;
        end
      endcase
      if (prev_clear) begin macc = 0; movf = 1'b0; end
      m_ack_prev = exp_ack;
      macc_w = macc[W-1:0];
      total++; if (gnt !== exp_gnt)   begin bad++; $display("FAIL rnd_gnt c%0d got=%b exp=%b", c, gnt, exp_gnt); end
      total++; if (ack !== exp_ack)   begin bad++; $display("FAIL rnd_ack c%0d got=%b exp=%b", c, ack, exp_ack); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy c%0d got=%b exp=%b", c, busy, exp_busy); end
      total++; if (acc_out !== macc_w) begin bad++; $display("FAIL rnd_acc c%0d got=%h exp=%h", c, acc_out, macc_w); end
      total++; if (ovf !== movf)      begin bad++; $display("FAIL rnd_ovf c%0d got=%b exp=%b", c, ovf, movf); end
      total++; if (led !== macc_w[23:16]) begin bad++; $display("FAIL rnd_led c%0d got=%h exp=%h", c, led, macc_w[23:16]); end
      req = req & ~exp_ack;
      just_acked = exp_ack;
    end
    clear = 1'b0;
    req = '0;
  endtask

  initial begin
    RST = 1'b1; req = '0; clear = 1'b0; value_flat = '0;
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_withdraw();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_rr_sched.md
Name: accum_rr_sched

Overview:
- Round-robin scheduler that shares one DATA_W-bit wrap-around accumulator among NUM_REQ requesters.
- Each requester posts an operand with a req/ack handshake. The block arbitrates, latches the operand, adds it to the accumulator, and acknowledges.
- Sits between the requesting front-end blocks and the LED status display. led shows accumulator bits [23:16].

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand and accumulator width (must be >= 24).

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset; synchronous, active-high.
- req  input  NUM_REQ  per-requester request level.
- value_flat  input  NUM_REQ*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W].
- clear  input  1  synchronous clear of accumulator and overflow flag.
- gnt  output  NUM_REQ  one-hot grant, registered.
- ack  output  NUM_REQ  one-hot single-cycle completion pulse, registered.
- busy  output  1  high when FSM is not in IDLE.
- acc_out  output  DATA_W  accumulator value.
- ovf  output  1  sticky carry-out flag.
- led  output  8  acc_out[23:16].

Behaviour:
- Reset (RST=1 at an edge), from any state:
  - state=IDLE; gnt=0, ack=0, acc_out=0, ovf=0.
  - Priority pointer last=NUM_REQ-1, so requester 0 has highest priority.
  - A transaction in flight is dropped silently: no ack, no add.
- FSM states: IDLE, LATCH, ADD.
- IDLE:
  - eff_req = req & ~ack. A requester is masked in the cycle its ack is visible.
  - If eff_req!=0: choose the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Register gnt=onehot(winner) and idx=winner; go LATCH.
  - Otherwise stay in IDLE.
- LATCH:
  - If req[idx]=1: operand <= value_flat[idx]; go ADD.
  - If req[idx]=0 (withdrawn): gnt<=0, go IDLE. No ack, no add; last is unchanged.
- ADD:
  - {carry, acc} <= acc + operand, result modulo 2^DATA_W; ovf <= ovf | carry.
  - ack <= onehot(idx); gnt <= 0; last <= idx; go IDLE.
  - req is ignored in this state because the operand is already latched.
- ack is high exactly one cycle (the cycle after ADD), coincident with the updated acc_out.
- Requester handshake obligations:
  - Hold req and its value from assertion until ack.
  - Drop req in the ack cycle, or re-present it later as a new transaction.
- Throughput: one transaction per 3 cycles. Grant visible 1 cycle after req sampled in IDLE; ack 3 cycles after the sampling edge.
- clear, any state:
  - acc<=0, ovf<=0. Overrides an ADD in the same cycle; the add result is discarded.
  - The ack is still issued, and FSM sequencing is unaffected.
- RST has priority over clear and all FSM actions.
- busy = (state != IDLE), combinational from the state register.
- gnt and ack are never both non-zero.
- gnt is never multi-hot.
- No combinational path from req to gnt or ack.

Test Plan:
- Single request: after reset, req=0001, value0=5, held until ack.
  - Required: gnt=0001 in cycles 1-2, ack=0001 in cycle 3, acc_out=5, led=0x00, busy high in cycles 1-2.
- All four request at once with values 1,2,3,4, each dropping req on its ack:
  - Grants in order 0,1,2,3; acks at cycles 3,6,9,12; final acc_out=10, ovf=0.
- Wrap and flag:
  - Accumulate to 0xFFFF_FFFE, then add 3 -> acc_out=0x0000_0001, ovf=1.
  - Add 0x0012_0000 -> led=0x12.
  - Pulse clear -> acc_out=0, ovf=0.
- Withdraw: req0=1, value=7; drop req0 in the LATCH cycle while req1=1, value=9.
  - Required: no ack[0], FSM returns to IDLE; requester 1 is served next.
  - acc_out=9 after ack[1]; a later req0 still has priority over req1 (pointer unchanged by the abort).
- Fairness: req0 and req2 continuously re-requesting (drop in ack cycle, re-raise next cycle).
  - Grants alternate 0,2,0,2; no requester receives two consecutive grants.
- Reset mid-operation: assert RST in the ADD cycle of a req1 value=100 transaction.
  - Next cycle: gnt=0, ack=0, acc_out=0, busy=0.
  - Then clear coincident with an ADD of 50 -> acc_out=0, ack still pulses.
